// File: rtl/ifm_pkg.sv
// Shared types for the instruction fetch memory: controller modes and the response entry layout.
package ifm_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DRAIN
    } ifm_state_e;

    localparam int          ADDR_W_DEF   = 8;
    localparam int          DATA_W_DEF   = 16;
    localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  oob;
    } rsp_entry_t;

endpackage

// File: rtl/ifm_rsp_fifo.sv
// Two-entry response FIFO; head is the oldest entry and flush empties it on a single edge.
module ifm_rsp_fifo
    import ifm_pkg::*;
#(
    parameter int W = $bits(rsp_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      cnt <= cnt + 2'd1;
            else if (pop && !push) cnt <= cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) slot[wr_ptr] <= push_data;
    end

    assign empty = (cnt == 2'd0);
    assign count = cnt;
    assign head  = slot[rd_ptr];

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a registered fetch port and a 2-entry response buffer.
// LOAD mode takes serial writes, RUN mode serves valid/ready fetches, DRAIN empties before LOAD.
module instr_fetch_mem
    import ifm_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    input  logic              start,
    input  logic              stop,
    output logic              running,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_oob
);
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] addr;
        logic              oob;
    } entry_t;

    localparam int              EW      = $bits(entry_t);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    ifm_state_e        state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    entry_t            rd_p1, fifo_head, rsp_head;
    logic              vld_p1;
    logic              fifo_empty, fifo_push, fifo_pop;
    logic [1:0]        fifo_count, occupancy;
    logic              accept, ld_ok, req_oob;

    assign ld_ok     = (state_q == S_LOAD) && ld_en && ({1'b0, ld_addr} < DEPTH_C);
    assign req_oob   = ({1'b0, req_addr} >= DEPTH_C);
    assign occupancy = fifo_count + {1'b0, vld_p1};
    assign running   = (state_q == S_RUN);
    assign req_ready = running && !flush && !occupancy[1];
    assign accept    = req_valid && req_ready;

    // The in-flight word is shown directly while the buffer is empty, so a lone
    // fetch answers one cycle after acceptance and is only buffered if not taken.
    assign rsp_valid = !fifo_empty || vld_p1;
    assign rsp_head  = fifo_empty ? rd_p1 : fifo_head;
    assign fifo_pop  = !fifo_empty && rsp_ready;
    assign fifo_push = vld_p1 && !(fifo_empty && rsp_ready);
    assign rsp_instr = rsp_valid ? rsp_head.instr : NOP_WORD;
    assign rsp_addr  = rsp_valid ? rsp_head.addr : '0;
    assign rsp_oob   = rsp_valid && rsp_head.oob;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (start && !stop) state_d = S_RUN;
            S_RUN:   if (stop) state_d = S_DRAIN;
            S_DRAIN: if (!vld_p1 && fifo_empty) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Flush holds req_ready low, so a flush edge also leaves nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            vld_p1  <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= accept;
            ld_err  <= ld_en && !ld_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_ok) mem[ld_addr] <= ld_data;
    end

    // p0 -> p1: synchronous array read; out-of-range fetches never index the array
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p1.instr <= req_oob ? NOP_WORD : mem[req_addr];
            rd_p1.addr  <= req_addr;
            rd_p1.oob   <= req_oob;
        end
    end

    ifm_rsp_fifo #(
        .W(EW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (rd_p1),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem (DEPTH=200) with a queue-based reference model checked every cycle.
module tb_instr_fetch_mem;

    localparam int MDEPTH = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_en, start, stop, flush, req_valid, rsp_ready;
    logic [7:0]  ld_addr, req_addr;
    logic [15:0] ld_data;
    logic        ld_err, running, req_ready, rsp_valid, rsp_oob;
    logic [15:0] rsp_instr;
    logic [7:0]  rsp_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .DEPTH    (MDEPTH),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .start     (start),
        .stop      (stop),
        .running   (running),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_oob   (rsp_oob)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: mode, array image, and the ordered list of owed responses.
    typedef struct {
        logic [15:0] instr;
        logic [7:0]  addr;
        logic        oob;
    } exp_t;

    exp_t        m_q[$];
    logic [15:0] m_mem [256];
    int          m_mode;    // 0 = LOAD, 1 = RUN, 2 = DRAIN
    logic        m_lderr;

    function automatic exp_t mk(input logic [7:0] a);
        exp_t e;
        e.addr  = a;
        e.oob   = (int'(a) >= MDEPTH);
        e.instr = e.oob ? 16'h0000 : m_mem[a];
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_mode  <= 0;
            m_lderr <= 1'b0;
        end else begin
            m_lderr <= ld_en && !(m_mode == 0 && int'(ld_addr) < MDEPTH);
            if (ld_en && m_mode == 0 && int'(ld_addr) < MDEPTH) m_mem[ld_addr] <= ld_data;
            case (m_mode)
                0: if (start && !stop) m_mode <= 1;
                1: if (stop) m_mode <= 2;
                2: if (m_q.size() == 0) m_mode <= 0;
                default: m_mode <= 0;
            endcase
            if (flush) m_q.delete();
            else begin
                case ({req_valid && m_mode == 1 && m_q.size() < 2, m_q.size() > 0 && rsp_ready})
                    2'b10: m_q.push_back(mk(req_addr));
                    2'b01: void'(m_q.pop_front());
                    2'b11: begin
                        void'(m_q.pop_front());
                        m_q.push_back(mk(req_addr));
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("running", 32'(running), 32'(m_mode == 1));
            chk("req_ready", 32'(req_ready), 32'(m_mode == 1 && !flush && m_q.size() < 2));
            chk("ld_err", 32'(ld_err), 32'(m_lderr));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("rsp_instr", 32'(rsp_instr), 32'(m_q[0].instr));
                chk("rsp_addr", 32'(rsp_addr), 32'(m_q[0].addr));
                chk("rsp_oob", 32'(rsp_oob), 32'(m_q[0].oob));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_ld_err"}, 32'(ld_err), 0);
        chk({tag, "_rsp_instr"}, 32'(rsp_instr), 0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
        chk({tag, "_rsp_oob"}, 32'(rsp_oob), 0);
    endtask

    logic [15:0] prog [8] = '{16'h1205, 16'h140A, 16'h2650, 16'h9610,
                              16'h4444, 16'h5555, 16'h6666, 16'h7777};

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; stop = 1'b0;
        flush = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // program load, last legal word, then a rejected out-of-range load
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
            tick();
        end
        ld_addr = 8'd199; ld_data = 16'hBEEF; tick();
        ld_addr = 8'd10;  ld_data = 16'hAAAA; tick();
        ld_addr = 8'd250; ld_data = 16'hFFFF; tick();
        ld_en = 1'b0;
        @(negedge clk); chk("lderr_oob_load", 32'(ld_err), 1);
        tick();
        @(negedge clk); chk("lderr_one_cycle", 32'(ld_err), 0);

        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk); chk("running_after_start", 32'(running), 1);

        // back-to-back fetches: one response per cycle, one cycle after acceptance
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 8'(i);
            tick();
            @(negedge clk);
            chk("b2b_valid", 32'(rsp_valid), 1);
            chk("b2b_instr", 32'(rsp_instr), 32'(prog[i]));
            chk("b2b_addr", 32'(rsp_addr), i);
        end
        req_valid = 1'b0; tick();
        @(negedge clk); chk("b2b_done", 32'(rsp_valid), 0);

        // consumer stalled: two accepted, third held off, then in-order release
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 8'd4; tick();
        req_addr = 8'd5; tick();
        req_addr = 8'd6;
        @(negedge clk); chk("stall_ready", 32'(req_ready), 0);
        tick();
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); chk("stall_first_addr", 32'(rsp_addr), 4); chk("stall_first_instr", 32'(rsp_instr), 16'h4444);
        tick();
        @(negedge clk); chk("stall_second_addr", 32'(rsp_addr), 5); chk("stall_second_instr", 32'(rsp_instr), 16'h5555);
        tick();
        @(negedge clk); chk("stall_empty", 32'(rsp_valid), 0);

        // range boundary: 199 is the last word, 200 and 255 are out of range
        req_valid = 1'b1; req_addr = 8'd199; tick();
        req_addr = 8'd200;
        @(negedge clk); chk("last_word_instr", 32'(rsp_instr), 16'hBEEF); chk("last_word_oob", 32'(rsp_oob), 0);
        tick();
        req_addr = 8'd255;
        @(negedge clk); chk("oob200_instr", 32'(rsp_instr), 0); chk("oob200_flag", 32'(rsp_oob), 1);
        tick();
        req_valid = 1'b0;
        @(negedge clk); chk("oob255_instr", 32'(rsp_instr), 0); chk("oob255_flag", 32'(rsp_oob), 1);
        chk("oob255_addr", 32'(rsp_addr), 255);

        // load attempt while running is rejected
        ld_en = 1'b1; ld_addr = 8'd0; ld_data = 16'hFFFF; tick(); ld_en = 1'b0;
        @(negedge clk); chk("lderr_run", 32'(ld_err), 1);

        // flush with one buffered and one in flight
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 8'd1; tick();
        req_addr = 8'd2; tick();
        req_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        @(negedge clk); chk("flush_full_valid", 32'(rsp_valid), 0);

        // flush with one in flight: request in the flush cycle is refused
        req_valid = 1'b1; req_addr = 8'd3; tick();
        flush = 1'b1; req_addr = 8'd2;
        @(negedge clk); chk("flush_ready", 32'(req_ready), 0);
        tick(); flush = 1'b0; req_valid = 1'b0;
        @(negedge clk); chk("flush_valid", 32'(rsp_valid), 0);

        // fresh fetch after flush; array unchanged by the rejected load
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd0; tick(); req_valid = 1'b0;
        @(negedge clk); chk("post_flush_instr", 32'(rsp_instr), 16'h1205); chk("post_flush_addr", 32'(rsp_addr), 0);
        tick();

        // stop with buffered data: DRAIN keeps popping, rejects loads, then returns to LOAD
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 8'd1; tick();
        req_addr = 8'd2; tick();
        req_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
        @(negedge clk); chk("drain_running", 32'(running), 0); chk("drain_req_ready", 32'(req_ready), 0);
        ld_en = 1'b1; ld_addr = 8'd10; ld_data = 16'h1111; tick(); ld_en = 1'b0;
        @(negedge clk); chk("lderr_drain", 32'(ld_err), 1); chk("drain_head", 32'(rsp_addr), 1);
        rsp_ready = 1'b1; tick();
        @(negedge clk); chk("drain_second", 32'(rsp_addr), 2); chk("drain_second_instr", 32'(rsp_instr), 16'h2650);
        tick();
        @(negedge clk); chk("drain_empty", 32'(rsp_valid), 0);
        tick();
        ld_en = 1'b1; ld_addr = 8'd10; ld_data = 16'h1111; tick(); ld_en = 1'b0;
        @(negedge clk); chk("lderr_back_in_load", 32'(ld_err), 0);

        // start and stop together in LOAD stays in LOAD
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        @(negedge clk); chk("start_stop_load", 32'(running), 0);
        start = 1'b1; tick(); start = 1'b0;
        req_valid = 1'b1; req_addr = 8'd10; tick(); req_valid = 1'b0;
        @(negedge clk); chk("reload_instr", 32'(rsp_instr), 16'h1111);
        tick();

        // asynchronous reset with two responses pending
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 8'd2; tick();
        req_addr = 8'd3; tick();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // array survives reset
        start = 1'b1; tick(); start = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 8'(i);
            tick();
            @(negedge clk);
            chk("restart_instr", 32'(rsp_instr), 32'(prog[i]));
        end
        req_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
